// File: rtl/stack_game_if.sv
// Player/renderer-facing signal bundle for the Sky Stacker sequencer.
// master drives start/drop and observes the game view; slave is the sequencer.
interface stack_game_if;
    logic        start;
    logic        drop;
    logic [9:0]  pos_x;
    logic [9:0]  width;
    logic [4:0]  height;
    logic [31:0] colors;
    logic        game_over;
    logic        win;

    modport master (
        output start, drop,
        input  pos_x, width, height, colors, game_over, win
    );

    modport slave (
        input  start, drop,
        output pos_x, width, height, colors, game_over, win
    );
endinterface

// File: rtl/stack_game_ctrl.sv
// Sky Stacker game sequencer: slides the active block, resolves drops into trim/grow/game over.
// Optional PERFECT_BONUS_EN: a perfect drop widens the next block by up to 4 pixels.
module stack_game_ctrl #(
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned INIT_W   = 150,
    parameter int unsigned INIT_X   = 300,
    parameter int unsigned TICK_DIV = 18,
    parameter int unsigned MAX_H    = 16
) (
    input logic         clk,
    input logic         rst,
    stack_game_if.slave bus
);

    localparam logic [10:0] ScreenW11 = 11'(SCREEN_W);
    localparam logic [9:0]  InitW     = 10'(INIT_W);
    localparam logic [9:0]  InitX     = 10'(INIT_X);
    localparam logic [4:0]  MaxH      = 5'(MAX_H);

    typedef enum logic [2:0] {StIdle, StSlide, StCheck, StGrow, StOver} state_e;

    state_e              state_q;
    logic [9:0]          pos_x_q, width_q, base_x_q, base_w_q, nx_q, nw_q;
    logic [4:0]          height_q;
    logic [31:0]         colors_q;
    logic                dir_left_q;
    logic [TICK_DIV-1:0] div_q;
    logic                game_over_q, win_q;
    logic [1:0]          code_q;

    logic        tick;
    logic [10:0] pos_end, base_end, lo, hi;
    logic [9:0]  ov_w, grow_w;
    logic [4:0]  height_inc;
    logic [1:0]  code_next;

    assign tick       = (div_q == '0);
    assign pos_end    = {1'b0, pos_x_q} + {1'b0, width_q};
    assign base_end   = {1'b0, base_x_q} + {1'b0, base_w_q};
    assign lo         = (pos_x_q > base_x_q) ? {1'b0, pos_x_q} : {1'b0, base_x_q};
    assign hi         = (pos_end < base_end) ? pos_end : base_end;
    assign ov_w       = hi[9:0] - lo[9:0];
    assign height_inc = height_q + 5'd1;

    always_comb begin
        code_next = 2'b10;
        unique case (code_q)
            2'b10:   code_next = 2'b11;
            2'b11:   code_next = 2'b01;
            default: code_next = 2'b10;
        endcase
    end

`ifdef PERFECT_BONUS_EN
    localparam logic [10:0] InitW11 = 11'(INIT_W);
    logic [10:0] bonus_w, room_w;

    always_comb begin
        bonus_w = {1'b0, nw_q} + 11'd4;
        if (bonus_w > InitW11) bonus_w = InitW11;
        room_w = ScreenW11 - {1'b0, nx_q};
        if (bonus_w > room_w) bonus_w = room_w;
        // Only a drop that kept the full moving width earns the bonus
        grow_w = (nw_q == width_q) ? bonus_w[9:0] : nw_q;
    end
`else
    assign grow_w = nw_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pos_x_q     <= InitX;
            width_q     <= InitW;
            base_x_q    <= InitX;
            base_w_q    <= InitW;
            nx_q        <= '0;
            nw_q        <= '0;
            height_q    <= 5'd1;
            colors_q    <= 32'h1;
            dir_left_q  <= 1'b0;
            div_q       <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            code_q      <= 2'b10;
        end else begin
            div_q <= div_q + TICK_DIV'(1);
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        pos_x_q    <= '0;
                        dir_left_q <= 1'b0;
                        state_q    <= StSlide;
                    end
                end
                StSlide: begin
                    // drop freezes the block even when a tick lands in the same cycle
                    if (bus.drop) begin
                        state_q <= StCheck;
                    end else if (tick) begin
                        if (!dir_left_q) begin
                            if (pos_end == ScreenW11) begin
                                dir_left_q <= 1'b1;
                                pos_x_q    <= pos_x_q - 10'd1;
                            end else begin
                                pos_x_q <= pos_x_q + 10'd1;
                            end
                        end else begin
                            if (pos_x_q == '0) begin
                                dir_left_q <= 1'b0;
                                pos_x_q    <= pos_x_q + 10'd1;
                            end else begin
                                pos_x_q <= pos_x_q - 10'd1;
                            end
                        end
                    end
                end
                StCheck: begin
                    if (hi <= lo) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                        win_q       <= 1'b0;
                    end else begin
                        nx_q    <= lo[9:0];
                        nw_q    <= ov_w;
                        state_q <= StGrow;
                    end
                end
                StGrow: begin
                    base_x_q                     <= nx_q;
                    base_w_q                     <= grow_w;
                    width_q                      <= grow_w;
                    colors_q[{height_q, 1'b0} +: 2] <= code_q;
                    code_q                       <= code_next;
                    height_q                     <= height_inc;
                    if (height_inc == MaxH) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                        win_q       <= 1'b1;
                    end else begin
                        pos_x_q    <= '0;
                        dir_left_q <= 1'b0;
                        state_q    <= StSlide;
                    end
                end
                StOver: begin
                    if (bus.start) begin
                        state_q     <= StIdle;
                        pos_x_q     <= InitX;
                        width_q     <= InitW;
                        base_x_q    <= InitX;
                        base_w_q    <= InitW;
                        height_q    <= 5'd1;
                        colors_q    <= 32'h1;
                        dir_left_q  <= 1'b0;
                        div_q       <= '0;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                        code_q      <= 2'b10;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.pos_x     = pos_x_q;
    assign bus.width     = width_q;
    assign bus.height    = height_q;
    assign bus.colors    = colors_q;
    assign bus.game_over = game_over_q;
    assign bus.win       = win_q;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Scoreboard bench for stack_game_ctrl: a game-level model predicts every post-edge view,
// a monitor compares the DUT against the queued predictions; directed checks cover key cases.
module tb_stack_game_ctrl;

    localparam int SCREEN_W = 640;
    localparam int INIT_W   = 150;
    localparam int INIT_X   = 300;
    localparam int TICK_DIV = 2;
    localparam int MAX_H    = 16;
    localparam int DIVN     = 1 << TICK_DIV;

    localparam int PH_IDLE  = 0;
    localparam int PH_SLIDE = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_GROW  = 3;
    localparam int PH_OVER  = 4;

    logic clk = 1'b0;
    logic rst;

    stack_game_if bus ();

    stack_game_ctrl #(
        .SCREEN_W(SCREEN_W),
        .INIT_W  (INIT_W),
        .INIT_X  (INIT_X),
        .TICK_DIV(TICK_DIV),
        .MAX_H   (MAX_H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  pos_x;
        logic [9:0]  width;
        logic [4:0]  height;
        logic [31:0] colors;
        logic        go;
        logic        win;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    // Game-level model: tower as a list of level colours, block as position plus step
    int m_phase, m_pos, m_w, m_bx, m_bw, m_h, m_step, m_cnt, m_nx, m_nw, m_go, m_win, m_pal;
    int lvl[16];
    int pal[3] = '{2, 3, 1};

    function void model_init();
        m_phase = PH_IDLE;
        m_pos = INIT_X; m_w = INIT_W; m_bx = INIT_X; m_bw = INIT_W;
        m_h = 1; m_step = 1; m_cnt = 0; m_go = 0; m_win = 0; m_pal = 0;
        m_nx = 0; m_nw = 0;
        for (int k = 0; k < 16; k++) lvl[k] = 0;
        lvl[0] = 1;
    endfunction

    function snap_t model_snap();
        snap_t s;
        logic [31:0] c;
        c = '0;
        for (int k = 0; k < 16; k++) c = c | (32'(lvl[k]) << (2 * k));
        s.pos_x = 10'(m_pos); s.width = 10'(m_w); s.height = 5'(m_h);
        s.colors = c; s.go = (m_go != 0); s.win = (m_win != 0);
        return s;
    endfunction

    function void model_step(input bit st, input bit dr);
        bit tick;
        int l, r, nwid;
        if (rst) begin
            model_init();
            return;
        end
        tick  = (m_cnt == 0);
        m_cnt = (m_cnt + 1) % DIVN;
        case (m_phase)
            PH_IDLE: if (st) begin m_pos = 0; m_step = 1; m_phase = PH_SLIDE; end
            PH_SLIDE: begin
                if (dr) m_phase = PH_CHECK;
                else if (tick) begin
                    if (m_step > 0 && m_pos + m_w == SCREEN_W) m_step = -1;
                    else if (m_step < 0 && m_pos == 0) m_step = 1;
                    m_pos = m_pos + m_step;
                end
            end
            PH_CHECK: begin
                l = (m_pos > m_bx) ? m_pos : m_bx;
                r = (m_pos + m_w < m_bx + m_bw) ? m_pos + m_w : m_bx + m_bw;
                if (r <= l) begin m_phase = PH_OVER; m_go = 1; m_win = 0; end
                else begin m_nx = l; m_nw = r - l; m_phase = PH_GROW; end
            end
            PH_GROW: begin
                nwid = m_nw;
`ifdef PERFECT_BONUS_EN
                if (m_nw == m_w) begin
                    nwid = m_nw + 4;
                    if (nwid > INIT_W) nwid = INIT_W;
                    if (nwid > SCREEN_W - m_nx) nwid = SCREEN_W - m_nx;
                end
`endif
                m_bx = m_nx; m_bw = nwid; m_w = nwid;
                lvl[m_h] = pal[m_pal];
                m_pal = (m_pal + 1) % 3;
                m_h = m_h + 1;
                if (m_h == MAX_H) begin m_phase = PH_OVER; m_go = 1; m_win = 1; end
                else begin m_pos = 0; m_step = 1; m_phase = PH_SLIDE; end
            end
            PH_OVER: if (st) model_init();
            default: ;
        endcase
    endfunction

    // Called at a negedge; returns at the following negedge
    task automatic cycle(input bit st, input bit dr);
        bus.start = st;
        bus.drop  = dr;
        model_step(st, dr);
        exp_q.push_back(model_snap());
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.drop  = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, act, act, req, req);
        end
    endtask

    task automatic run_until_pos(input int target, input bit need_tick);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (m_phase == PH_SLIDE && m_pos == target && (!need_tick || m_cnt == 0)) begin
                ok = 1'b1;
                break;
            end
            cycle(1'b0, 1'b0);
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_pos: pos_x %0d not reached, model at %0d", target, m_pos);
        end
    endtask

    task automatic check_idle_view(input string tag);
        check({tag, " pos_x"}, 32'(bus.pos_x), 32'(INIT_X));
        check({tag, " width"}, 32'(bus.width), 32'(INIT_W));
        check({tag, " height"}, 32'(bus.height), 32'd1);
        check({tag, " colors"}, bus.colors, 32'h1);
        check({tag, " game_over"}, 32'(bus.game_over), 32'd0);
        check({tag, " win"}, 32'(bus.win), 32'd0);
    endtask

    // Monitor: the view is presented after every edge; compare against the prediction
    initial begin
        snap_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.pos_x = bus.pos_x; a.width = bus.width; a.height = bus.height;
                a.colors = bus.colors; a.go = bus.game_over; a.win = bus.win;
                n_cmp++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got pos_x=%0d width=%0d height=%0d colors=%h go=%0b win=%0b, expected pos_x=%0d width=%0d height=%0d colors=%h go=%0b win=%0b",
                             $time, a.pos_x, a.width, a.height, a.colors, a.go, a.win,
                             e.pos_x, e.width, e.height, e.colors, e.go, e.win);
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_colors;
        bit st, dr;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.drop  = 1'b0;
        model_init();
        @(negedge clk);
        check_idle_view("reset");
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        rst = 1'b0;

        // Idle holds without start
        repeat (20) cycle(1'b0, 1'b0);
        check_idle_view("idle hold");

        // Trim: drop at 200 against base 300..449
        cycle(1'b1, 1'b0);
        run_until_pos(200, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("trim pos_x", 32'(bus.pos_x), 32'd0);
        check("trim width", 32'(bus.width), 32'd50);
        check("trim height", 32'(bus.height), 32'd2);
        check("trim colors", bus.colors, 32'h9);

        // Miss at pos 0
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("miss game_over", 32'(bus.game_over), 32'd1);
        check("miss win", 32'(bus.win), 32'd0);
        check("miss height", 32'(bus.height), 32'd2);
        cycle(1'b1, 1'b0);
        check_idle_view("restart");

        // Bounce at right edge and at left edge
        cycle(1'b1, 1'b0);
        run_until_pos(490, 1'b0);
        repeat (DIVN) cycle(1'b0, 1'b0);
        check("bounce right", 32'(bus.pos_x), 32'd489);
        run_until_pos(0, 1'b0);
        repeat (DIVN) cycle(1'b0, 1'b0);
        check("bounce left", 32'(bus.pos_x), 32'd1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("far miss game_over", 32'(bus.game_over), 32'd1);
        cycle(1'b1, 1'b0);

        // Perfect drops, each landing on a tick cycle, until the tower wins
        cycle(1'b1, 1'b0);
        for (int lv = 1; lv < MAX_H; lv++) begin
            run_until_pos(300, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
            if (lv == 1) check("perfect freeze width", 32'(bus.width), 32'd150);
        end
        exp_colors = 32'h1;
        for (int k = 1; k < MAX_H; k++) exp_colors = exp_colors | (32'(pal[(k - 1) % 3]) << (2 * k));
        check("win height", 32'(bus.height), 32'd16);
        check("win flag", 32'(bus.win), 32'd1);
        check("win game_over", 32'(bus.game_over), 32'd1);
        check("win colors", bus.colors, exp_colors);
        check("win base width", 32'(bus.width), 32'd150);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);

        // Randomized play, drops biased toward positions near the base
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            st = ($urandom_range(0, 149) == 0);
            if (m_phase == PH_SLIDE && m_pos > m_bx - 40 && m_pos < m_bx + 40)
                dr = ($urandom_range(0, 7) == 0);
            else
                dr = ($urandom_range(0, 199) == 0);
            cycle(st, dr);
        end

        // Asynchronous reset while in GROW
        rst = 1'b1;
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        run_until_pos(250, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("reached grow", 32'(m_phase), 32'(PH_GROW));
        rst = 1'b1;
        #1;
        model_init();
        check_idle_view("async reset");
        @(negedge clk);
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b1, 1'b0);
        check("start after reset", 32'(bus.pos_x), 32'd0);
        repeat (10) cycle(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
